// File: rtl/regfile.sv
// Register file: DEPTH words of WIDTH bits, one synchronous write port, two
// combinational read ports, optional hardwired-zero word and write-to-read bypass.
module regfile #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_EN  = 1,
  parameter  int ZERO_IDX = DEPTH - 1,
  parameter  int BYPASS   = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [WIDTH-1:0]  rdDataA,
  output logic [WIDTH-1:0]  rdDataB
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZIDX    = ADDR_W'(ZERO_IDX);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && (a == ZIDX);
  endfunction

  logic [WIDTH-1:0] word [DEPTH];
  logic             wr_legal;
  logic             byp_a;
  logic             byp_b;

  assign wr_legal = wrEn && in_range(wrAddr) && !is_zero(wrAddr);

  // Bypass is held off during reset so outputs stay 0 while rst is low.
  assign byp_a = (BYPASS != 0) && rst && wr_legal && (rdAddrA == wrAddr);
  assign byp_b = (BYPASS != 0) && rst && wr_legal && (rdAddrB == wrAddr);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if ((ZERO_EN != 0) && (i == ZERO_IDX)) begin : g_zero
      assign word[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] q;
      logic             en;

      assign en = wr_legal && (wrAddr == ADDR_W'(i));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q <= '0;
        end else if (en) begin
          q <= wrData;
        end
      end

      assign word[i] = q;
    end
  end

  // Out-of-range and zero-register checks come first so an illegal address
  // never selects wrData or an undefined array element.
  always_comb begin
    rdDataA = word[rdAddrA];
    if (!in_range(rdAddrA) || is_zero(rdAddrA)) begin
      rdDataA = '0;
    end else if (byp_a) begin
      rdDataA = wrData;
    end
  end

  always_comb begin
    rdDataB = word[rdAddrB];
    if (!in_range(rdAddrB) || is_zero(rdAddrB)) begin
      rdDataB = '0;
    end else if (byp_b) begin
      rdDataB = wrData;
    end
  end

endmodule

// File: doc/regfile.md
# regfile

Parametrised multi-register file built from enabled, asynchronously cleared storage words: one synchronous write port, two combinational read ports, a configurable hardwired-zero register and optional write-to-read bypass. It is the datapath register file for the single-cycle CPU. It generalises the single 32-bit enabled register to DEPTH words of WIDTH bits with address decode, read muxing and read-during-write rules.

## Interface

- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; any value 2..256, not required to be a power of two.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- ZERO_EN, 1, when 1 register ZERO_IDX always reads 0 and ignores writes.
- ZERO_IDX, DEPTH-1, index of the hardwired-zero register; must be < DEPTH.
- BYPASS, 0, when 1 a read of the address being written this cycle returns wrData instead of the stored value.

Ports:

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; clears every register to 0 immediately.
- wrEn  input  1  write enable, sampled at posedge clk.
- wrAddr  input  ADDR_W  write address.
- wrData  input  WIDTH  write data.
- rdAddrA  input  ADDR_W  read port A address.
- rdAddrB  input  ADDR_W  read port B address.
- rdDataA  output  WIDTH  read port A data, combinational from state and inputs.
- rdDataB  output  WIDTH  read port B data, combinational from state and inputs.

## Operation

- Storage: DEPTH words, each a WIDTH-bit enabled register with async active-low clear. Word i is enabled iff wrEn && wrAddr==i && the write is legal.
- A write is legal iff wrAddr < DEPTH and not (ZERO_EN && wrAddr==ZERO_IDX). Illegal writes are silently dropped; no other word changes.
- Read ports are fully independent; both may address the same word.
- Read value, per port, in priority order:
  - rdAddr >= DEPTH gives 0.
  - ZERO_EN && rdAddr==ZERO_IDX gives 0.
  - BYPASS && wrEn && rdAddr==wrAddr gives wrData. This only applies when the write is legal; the first two rules already cover the illegal cases.
  - Otherwise the stored word.
- With BYPASS=0, a read of the address being written returns the old value until after the edge.
- Reset: while rst=0, all words are 0, so both rdData outputs are 0 regardless of addresses, and writes are ignored. Reset release is synchronised externally; the block does not re-synchronise it.
- The ZERO_IDX storage word may be optimised away; observable behaviour is unchanged.

## Timing

- Write latency is 1 cycle. Data presented with wrEn=1 before posedge N is readable combinationally right after edge N.
- Read latency is 0 cycles (combinational). With BYPASS=1 there is a combinational path wrData to rdData.
- Async reset assertion clears all words within the same cycle, including mid-write: a write whose edge coincides with rst=0 is lost.
- Writing the same address on consecutive cycles: the last write wins. Writing while reading another address does not disturb the read.
- The X/Z state of unselected inputs (wrData when wrEn=0) must not reach any output.

## Test plan

- Reset: write 0xDEADBEEF to r5, then pulse rst=0 asynchronously between edges -> rdDataA(r5)=0 immediately, with no clock edge.
- Write/read all: write i*0x01010101 to every r0..r30 (defaults) -> both ports read back the matching value at every address; r31 reads 0.
- Zero register: wrEn=1, wrAddr=31, wrData=0xFFFFFFFF -> rdDataA(31)=0, and all other words are unchanged.
- Read-during-write: r3=0x11, then write 0x22 to r3 while reading r3 -> rdData=0x11 before the edge with BYPASS=0, or 0x22 with BYPASS=1; 0x22 after the edge in both cases.
- Non-power-of-two depth: DEPTH=20, WIDTH=8; write 0xAA to addr 25 -> ignored; reading addr 25 gives 0; r0..r19 are unchanged.
- Dual port: rdAddrA=rdAddrB=7 with r7=0x1234 -> both ports show 0x1234. With wrEn=0 and wrData=X -> outputs carry no X.
